keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad: one column is driven low at a time, the row lines are sampled, and the result is debounced over whole scans. Each accepted key press produces a 4-bit hex code and a one-cycle strobe. The block sits on the input side of the keypad-to-display path and feeds its `data` output directly to the seven-segment driver.

## Interface
- `SCAN_DIV`, default 5000: clock cycles each column is driven (dwell); minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results required to change state; minimum 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `row` input 4: keypad rows, active-low (pulled up externally); asynchronous to `clk`.
- `col` output 4: keypad column drive, active-low, exactly one bit low at all times.
- `data` output 4: code of the last accepted key.
- `valid` output 1: one-cycle pulse when a new key is accepted.
- `key_down` output 1: high while the accepted key is held.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column sequencer:
  - Dwell counter counts 0..SCAN_DIV-1, then wraps.
  - Column index 0..3 advances when the dwell counter wraps; 3 wraps to 0.
  - `col` = ~(1 << index).
- Row sampling:
  - Synchronized `row` is sampled on the last dwell cycle (count = SCAN_DIV-1) of each column.
  - Per scan, the block accumulates the number of low row bits and the (r,c) of the last hit.
- Key map (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan result is evaluated at the column-3 sample. It is one of:
  - NONE: zero hits.
  - KEY(code): exactly one hit.
  - MULTI: two or more hits.
- Stability counter (saturates at DEBOUNCE_SCANS):
  - Result equals the previous scan's result (same class and same code): increment.
  - Otherwise: reset to 1.
  - MULTI always resets the counter to 0 and never causes a state change.
- FSM:
  - IDLE → PRESSED when the counter reaches DEBOUNCE_SCANS with result KEY(code). Effects: `data` <= code, `valid` pulses, `key_down` <= 1.
  - PRESSED → IDLE when the counter reaches DEBOUNCE_SCANS with result NONE. Effect: `key_down` <= 0.
  - In PRESSED, a stable KEY with a different code produces no `valid` and does not update `data`. The key must be released to NONE first (no roll-over).
  - Holding a key never re-triggers `valid`.
- Reset values:
  - `col` = 4'b1110.
  - `data` = 0, `valid` = 0, `key_down` = 0.
  - FSM = IDLE; dwell counter, column index, stability counter and previous result are cleared; previous result = NONE.
- Reset asserted mid-press: all state returns to the reset values immediately. After release of reset, a still-held key is treated as a new press and produces `valid` after DEBOUNCE_SCANS full scans.

## Timing
- Scan period = 4·SCAN_DIV cycles, with column 0 starting the cycle after reset release.
- Row-to-sample latency: at least 2 cycles of synchronizer, plus settle within the dwell.
- `valid` and the new `data` appear together on the clock edge following the column-3 sample of the qualifying scan.
- `data` is stable from that edge until the next accepted press.
- `valid` is high for exactly one cycle.
- `key_down` rises in the same cycle as `valid`. It falls one cycle after the column-3 sample of the DEBOUNCE_SCANS-th consecutive NONE scan.
- A press that is already held before a scan starts is accepted at the end of scan number DEBOUNCE_SCANS. Worst case is DEBOUNCE_SCANS+1 scans when the press begins mid-scan.

## Test plan
Parameters for all tests: SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan = 16 cycles).
1. Reset, no key → `col` cycles 1110, 1101, 1011, 0111 every 4 cycles; `valid` never asserts; `data`=0, `key_down`=0.
2. Hold key "5" (`row[1]` low whenever `col[1]` is low) from reset release → exactly one `valid` pulse, at the end of scan 3, with `data`=4'h5. `key_down` stays 1 while held and falls 1 cycle after the 3rd NONE scan following release.
3. Bounce key "D" (r3,c3), alternating pressed/released per scan for 4 scans, then held → no `valid` during the bounce; exactly one `valid` with `data`=4'hD after 3 stable scans.
4. Hold "1" and "9" simultaneously → MULTI; no `valid`, `data` unchanged. Then release "9" → `valid` with `data`=4'h1 after 3 scans.
5. Hold "A" until accepted, then slide to "B" without a NONE scan → no second `valid`, `data` stays 4'hA. Release for 3 scans, then press "B" → `valid` with `data`=4'hB.
6. Assert `rst_n` low while "7" is held and accepted → `data`=0, `key_down`=0 and `col`=1110 asynchronously. Release reset with "7" still held → new `valid` with `data`=4'h7 after 3 scans.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin and result bundle.
// The slave side is the scanner, the master side is the keypad/consumer.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] data;
    logic       valid;
    logic       key_down;

    modport master (
        output row,
        input  col, data, valid, key_down
    );

    modport slave (
        input  row,
        output col, data, valid, key_down
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debouncing.
// Emits a hex code plus one-cycle strobe per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic             clk,
    input logic             rst_n,
    keypad_scanner_if.slave kp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    typedef enum logic {IDLE, PRESSED} state_t;
    typedef enum logic [1:0] {R_NONE, R_KEY, R_MULTI} res_t;

    logic [3:0]    row_m;
    logic [3:0]    row_s;
    logic [CW-1:0] dwell;
    logic [1:0]    idx;
    logic [1:0]    hits;
    logic [3:0]    hit_rc;
    res_t          prev_res;
    logic [3:0]    prev_code;
    logic [SW-1:0] stab;
    state_t        state;
    state_t        state_d;

    logic          sample;
    logic          eval;
    logic [2:0]    col_hits;
    logic [1:0]    col_row;
    logic [2:0]    tot;
    logic [1:0]    tot_sat;
    logic [3:0]    cur_rc;
    res_t          res_cls;
    logic [3:0]    res_code;
    logic [SW-1:0] stab_n;
    logic [3:0]    data_d;
    logic          valid_d;
    logic          key_down_d;

    assign sample = (dwell == CW'(SCAN_DIV - 1));
    assign eval   = sample && (idx == 2'd3);
    assign kp.col = ~(4'b0001 << idx);

    // Hits in the column currently being sampled, merged with the scan so far.
    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        tot     = {1'b0, hits} + col_hits;
        tot_sat = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        cur_rc  = (col_hits != 3'd0) ? {col_row, idx} : hit_rc;
    end

    always_comb begin
        res_cls  = R_NONE;
        res_code = 4'h0;
        if (tot == 3'd1) begin
            res_cls  = R_KEY;
            res_code = KEY_MAP[cur_rc];
        end else if (tot >= 3'd2) begin
            res_cls = R_MULTI;
        end
        if (res_cls == R_MULTI) begin
            stab_n = '0;
        end else if (res_cls == prev_res && res_code == prev_code) begin
            stab_n = (stab == SW'(DEBOUNCE_SCANS)) ? stab : stab + SW'(1);
        end else begin
            stab_n = SW'(1);
        end
    end

    always_comb begin
        state_d    = state;
        data_d     = kp.data;
        valid_d    = 1'b0;
        key_down_d = kp.key_down;
        if (eval && stab_n == SW'(DEBOUNCE_SCANS)) begin
            unique case (state)
                IDLE: begin
                    if (res_cls == R_KEY) begin
                        state_d    = PRESSED;
                        data_d     = res_code;
                        valid_d    = 1'b1;
                        key_down_d = 1'b1;
                    end
                end
                PRESSED: begin
                    if (res_cls == R_NONE) begin
                        state_d    = IDLE;
                        key_down_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m       <= 4'hF;
            row_s       <= 4'hF;
            dwell       <= '0;
            idx         <= 2'd0;
            hits        <= 2'd0;
            hit_rc      <= 4'd0;
            prev_res    <= R_NONE;
            prev_code   <= 4'h0;
            stab        <= '0;
            state       <= IDLE;
            kp.data     <= 4'h0;
            kp.valid    <= 1'b0;
            kp.key_down <= 1'b0;
        end else begin
            row_m       <= kp.row;
            row_s       <= row_m;
            state       <= state_d;
            kp.data     <= data_d;
            kp.valid    <= valid_d;
            kp.key_down <= key_down_d;
            if (sample) begin
                dwell <= '0;
                idx   <= idx + 2'd1;
                if (eval) begin
                    hits      <= 2'd0;
                    hit_rc    <= 4'd0;
                    prev_res  <= res_cls;
                    prev_code <= res_code;
                    stab      <= stab_n;
                end else begin
                    hits   <= tot_sat;
                    hit_rc <= cur_rc;
                end
            end else begin
                dwell <= dwell + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model.
// Accepted codes are queued at press time and matched on each valid.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0;
    logic [3:0]  row_v;
    logic [3:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          n;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif.slave)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) is bit r*4+c; it pulls row r low while col c is low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_v[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kif.col[c]) row_v[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_v;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (kif.valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid got=%0h exp=none", kif.data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (kif.data === e) else begin
                    errors++;
                    $error("FAIL valid_data got=%0h exp=%0h", kif.data, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!kif.valid && cnt < 100);
    endtask

    initial begin
        logic [3:0] ecol;

        // 1: idle scanning
        do_reset();
        check("rst_col", kif.col, 4'b1110);
        check("rst_data", kif.data, 4'h0);
        check("rst_valid", kif.valid, 1'b0);
        check("rst_key_down", kif.key_down, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step();
            ecol = ~(4'b0001 << ((i / 4) % 4));
            check("col_seq", kif.col, ecol);
        end
        check("idle_data", kif.data, 4'h0);
        check("idle_key_down", kif.key_down, 1'b0);

        // 2: key 5 held from reset release
        keys = 16'h0020;
        do_reset();
        exp_q.push_back(4'h5);
        wait_valid(n);
        check("k5_latency", n, 48);
        check("k5_key_down", kif.key_down, 1'b1);
        step();
        check("k5_pulse_width", kif.valid, 1'b0);
        repeat (15) step();
        check("k5_held", kif.key_down, 1'b1);
        keys = 16'h0;
        n = 0;
        while (kif.key_down && n < 100) begin
            step();
            n++;
        end
        check("k5_release_lat", n, 48);
        check("k5_data_hold", kif.data, 4'h5);

        // 3: bouncing D, then held
        keys = 16'h0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            keys = (k % 2 == 0) ? 16'h8000 : 16'h0000;
            repeat (16) step();
        end
        check("bounce_no_key", kif.key_down, 1'b0);
        exp_q.push_back(4'hD);
        keys = 16'h8000;
        wait_valid(n);
        check("kD_latency", n, 48);
        keys = 16'h0;
        repeat (48) step();

        // 4: 1 + 9 together, then 9 released
        do_reset();
        keys = 16'h0401;
        repeat (64) step();
        check("multi_data", kif.data, 4'h0);
        check("multi_key_down", kif.key_down, 1'b0);
        keys = 16'h0001;
        exp_q.push_back(4'h1);
        wait_valid(n);
        check("k1_latency", n, 48);
        keys = 16'h0;
        repeat (48) step();

        // 5: A accepted, slide to B, release, press B
        do_reset();
        keys = 16'h0008;
        exp_q.push_back(4'hA);
        wait_valid(n);
        check("kA_latency", n, 48);
        keys = 16'h0080;
        repeat (64) step();
        check("slide_data", kif.data, 4'hA);
        check("slide_key_down", kif.key_down, 1'b1);
        keys = 16'h0;
        repeat (48) step();
        check("slide_release", kif.key_down, 1'b0);
        keys = 16'h0080;
        exp_q.push_back(4'hB);
        wait_valid(n);
        check("kB_latency", n, 48);
        check("kB_data", kif.data, 4'hB);

        // 6: reset while 7 held
        keys = 16'h0;
        do_reset();
        keys = 16'h0100;
        exp_q.push_back(4'h7);
        wait_valid(n);
        check("k7_latency", n, 48);
        repeat (5) step();
        check("k7_pre_key_down", kif.key_down, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_data", kif.data, 4'h0);
        check("async_key_down", kif.key_down, 1'b0);
        check("async_col", kif.col, 4'b1110);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(4'h7);
        wait_valid(n);
        check("k7_after_rst", n, 48);
        keys = 16'h0;
        repeat (48) step();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
